// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 decryptor: forward key expansion to rk10, then one inverse
// round per clock with the inverse key schedule computed on the fly. A one-entry
// key cache lets a repeated key skip the forward expansion.
module aes_inv_cipher_core #(
  parameter int NR        = 10,
  parameter int KEY_REUSE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] i_block,
  input  logic [127:0] init_key,
  input  logic         i_valid,
  output logic         ready,
  output logic [127:0] o_block,
  output logic         block_finish
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_INIT   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_FINAL  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [127:0]  key_q, key_d;          // working round key
  logic [127:0]  blk_q, blk_d;          // ciphertext / cipher state
  logic [127:0]  key_in_q, key_in_d;    // key captured at accept
  logic [127:0]  cache_key_q, cache_key_d;
  logic [127:0]  cache_rk_q, cache_rk_d;
  logic          cache_vld_q, cache_vld_d;
  logic [127:0]  o_block_q, o_block_d;
  logic          finish_q, finish_d;
  logic          ready_q, ready_d;
  logic          key_hit_s;

  // ---------------- GF(2^8) and S-box helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = a;
    res = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox_fwd(w[23:16]), sbox_fwd(w[15:8]), sbox_fwd(w[7:0]), sbox_fwd(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- key schedule steps ----------------
  function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [3:0] i);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rcon(i), 24'h000000};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [3:0] i);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot_word(w3) ^ {rcon(i), 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  // ---------------- inverse round transforms ----------------
  // Combined InvShiftRows + InvSubBytes: row r of column c comes from column c-r.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] x);
    logic [127:0] y;
    y = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        y[127 - 8*(4*c + r) -: 8] = sbox_inv(x[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
      end
    end
    return y;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0]   a0, a1, a2, a3;
    y = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127 - 32*c -: 8];
      a1 = x[119 - 32*c -: 8];
      a2 = x[111 - 32*c -: 8];
      a3 = x[103 - 32*c -: 8];
      y[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      y[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      y[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      y[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return y;
  endfunction

  assign key_hit_s    = (KEY_REUSE != 0) && cache_vld_q && (init_key == cache_key_q);
  assign ready        = ready_q;
  assign o_block      = o_block_q;
  assign block_finish = finish_q;

  // Next-state and datapath: sequencer for key expansion and inverse rounds.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    key_d       = key_q;
    blk_d       = blk_q;
    key_in_d    = key_in_q;
    cache_key_d = cache_key_q;
    cache_rk_d  = cache_rk_q;
    cache_vld_d = cache_vld_q;
    o_block_d   = o_block_q;
    finish_d    = 1'b0;
    ready_d     = ready_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid && ready_q) begin
          blk_d    = i_block;
          key_in_d = init_key;
          ready_d  = 1'b0;
          if (key_hit_s) begin
            key_d   = cache_rk_q;
            round_d = 4'd0;
            state_d = ST_INIT;
          end else begin
            key_d   = init_key;
            round_d = 4'd1;
            state_d = ST_KEYEXP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_KEYEXP: begin
        key_d = fwd_key(key_q, round_q);
        if (round_q == 4'(NR)) begin
          cache_key_d = key_in_q;
          cache_rk_d  = key_d;
          cache_vld_d = 1'b1;
          round_d     = 4'd0;
          state_d     = ST_INIT;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      ST_INIT: begin
        blk_d   = blk_q ^ key_q;
        key_d   = inv_key(key_q, 4'(NR));
        round_d = 4'(NR - 1);
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        blk_d = inv_mix_columns(inv_shift_sub(blk_q) ^ key_q);
        key_d = inv_key(key_q, round_q);
        if (round_q == 4'd1) begin
          round_d = 4'd0;
          state_d = ST_FINAL;
        end else begin
          round_d = round_q - 4'd1;
        end
      end
      ST_FINAL: begin
        o_block_d = inv_shift_sub(blk_q) ^ key_q;
        finish_d  = 1'b1;
        ready_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset that aborts any block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      round_q     <= 4'd0;
      key_q       <= 128'h0;
      blk_q       <= 128'h0;
      key_in_q    <= 128'h0;
      cache_key_q <= 128'h0;
      cache_rk_q  <= 128'h0;
      cache_vld_q <= 1'b0;
      o_block_q   <= 128'h0;
      finish_q    <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      key_q       <= key_d;
      blk_q       <= blk_d;
      key_in_q    <= key_in_d;
      cache_key_q <= cache_key_d;
      cache_rk_q  <= cache_rk_d;
      cache_vld_q <= cache_vld_d;
      o_block_q   <= o_block_d;
      finish_q    <= finish_d;
      ready_q     <= ready_d;
    end
  end

endmodule
